muldiv: RTL and testbench

Iterative multiply/divide unit for the MIPS execute stage, sitting beside the combinational `alu` and owning the architectural HI/LO registers. It accepts one MULT/MULTU/DIV/DIVU request at a time and runs it for a fixed number of cycles: one radix-2 iteration per cycle plus one sign-fixup cycle. It signals `busy` so the pipeline control stalls MFHI/MFLO and later mul/div issues until the result is committed. It also services MTHI/MTLO writes.

---
 rtl/muldiv.sv | 154 +++++++++++++++
 tb/tb_muldiv.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2 shift-add multiply,
// restoring divide, one iteration per cycle followed by a single sign-fixup cycle.
module muldiv #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic                 hi_we,
    input  logic                 lo_we,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int W  = WORD_SIZE;
    localparam int W2 = 2 * WORD_SIZE;
    localparam int CW = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dz;
    logic [W-1:0]    r_a_raw;
    logic [W-1:0]    r_opnd;
    logic [W2-1:0]   r_acc;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_busy;
    logic            r_done;

    // Signed ops have op[0]==0; their operands are reduced to magnitudes.
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;

    assign w_a_neg = ~op[0] & a[W-1];
    assign w_b_neg = ~op[0] & b[W-1];
    assign w_a_mag = w_a_neg ? (W'(0) - a) : a;
    assign w_b_mag = w_b_neg ? (W'(0) - b) : b;

    // Multiply step: accumulator high half gathers partial sums, multiplier shifts out low.
    logic [W:0]      w_mul_sum;
    logic [W2-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[W2-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : (W+1)'(0));
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide step: remainder in the high half, dividend shifting into it, quotient bits entering low.
    logic [W:0]      w_div_shift;
    logic            w_div_ge;
    logic [W-1:0]    w_div_sub;
    logic [W-1:0]    w_div_rem;
    logic [W2-1:0]   w_div_next;

    assign w_div_shift = {r_acc[W2-1:W], r_acc[W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_sub   = w_div_shift[W-1:0] - r_opnd;
    assign w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[W-1:0];
    assign w_div_next  = {w_div_rem, r_acc[W-2:0], w_div_ge};

    logic [W2-1:0]   w_prod_fix;
    logic [W-1:0]    w_quo_fix;
    logic [W-1:0]    w_rem_fix;

    assign w_prod_fix = r_neg_q ? (W2'(0) - r_acc) : r_acc;
    assign w_quo_fix  = r_neg_q ? (W'(0) - r_acc[W-1:0]) : r_acc[W-1:0];
    assign w_rem_fix  = r_neg_r ? (W'(0) - r_acc[W2-1:W]) : r_acc[W2-1:W];

    // Control FSM, iteration datapath and HI/LO architectural state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_a_raw  <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dz     <= (b == W'(0));
                        r_a_raw  <= a;
                        r_opnd   <= op[1] ? w_b_mag : w_a_mag;
                        r_acc    <= {W'(0), (op[1] ? w_a_mag : w_b_mag)};
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt == CW'(W - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_dz) begin
                        r_hi <= r_a_raw;
                        r_lo <= {W{1'b1}};
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: expected {hi,lo} pushed at issue, popped on done.
module tb_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    logic [63:0]   exp_q[$];
    logic [31:0]   m_hi;
    logic [31:0]   m_lo;
    logic          seen_done;

    muldiv #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sa;
        longint      sb;
        longint      q;
        longint      rm;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] r;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = 64'd0;
        case (o)
            2'd0: r = sa * sb;
            2'd1: r = ux * uy;
            2'd2: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(e);
        step();
        start = 1'b0;
        cyc   = 1;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    // cyc counts negedges since the start strobe; done is visible at the 34th (E0..E33 is 33 cycles).
    task automatic wait_done();
        logic [63:0] e;
        while (!done && cyc < 60) step();
        check("latency", 64'(cyc), 64'(W + 2));
        check("busy_in_done", {63'd0, busy}, 64'd0);
        check("queue_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", {hi, lo}, e);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    task automatic run_one(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
        issue(o, x, y, e);
        wait_done();
        step();
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) step();
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        step();

        hi_we = 1'b1; wdata = 32'h0000_1234; step(); hi_we = 1'b0;
        check("mthi", {hi, lo}, {32'h0000_1234, 32'd0});
        lo_we = 1'b1; wdata = 32'h0000_5678; step(); lo_we = 1'b0;
        check("mtlo", {hi, lo}, {32'h0000_1234, 32'h0000_5678});
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_A5A5; step();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo_same_edge", {hi, lo}, {32'h0000_A5A5, 32'h0000_A5A5});
        rst = 1'b1; step(); rst = 1'b0;
        check("reset_clears_hilo", {hi, lo}, 64'd0);
        check("reset_busy_idle", {63'd0, busy}, 64'd0);

        run_one(2'd0, 32'hFFFFFFFF, 32'd7, 64'hFFFFFFFF_FFFFFFF9);
        run_one(2'd1, 32'hFFFFFFFF, 32'd7, 64'h00000006_FFFFFFF9);
        run_one(2'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_one(2'd2, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        run_one(2'd3, 32'd100, 32'd7, 64'h00000002_0000000E);
        run_one(2'd3, 32'h00000055, 32'd0, 64'h00000055_FFFFFFFF);
        run_one(2'd2, 32'hFFFFFFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF);
        run_one(2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_one(2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);

        // Stray start and MTHI while busy must be dropped.
        issue(2'd1, 32'd3, 32'd5, 64'd15);
        repeat (3) step();
        start = 1'b1; op = 2'd2; a = 32'd999; b = 32'd3;
        hi_we = 1'b1; wdata = 32'h0000_DEAD;
        step();
        start = 1'b0; hi_we = 1'b0;
        check("hi_hold_while_busy", {hi, lo}, {m_hi, m_lo});
        wait_done();

        // Issue in the done cycle, with an MTHI on the same edge.
        hi_we = 1'b1; wdata = 32'h0000_BEEF;
        issue(2'd3, 32'd1000, 32'd33, 64'h0000000A_0000001E);
        hi_we = 1'b0;
        check("write_with_start", {32'd0, hi}, {32'd0, 32'h0000_BEEF});
        wait_done();
        step();

        // Reset during the tenth RUN cycle aborts the op.
        issue(2'd0, 32'h00012345, 32'h00006789, model(2'd0, 32'h00012345, 32'h00006789));
        repeat (9) step();
        rst = 1'b1; step(); rst = 1'b0;
        void'(exp_q.pop_back());
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            step();
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {63'd0, seen_done}, 64'd0);
        run_one(2'd2, 32'hFFFFFF00, 32'd7, model(2'd2, 32'hFFFFFF00, 32'd7));

        // Random back-to-back ops.
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if (i % 2 == 0) ry = ry >> 24;
            if (i == 5) ry = 32'd0;
            issue(ro, rx, ry, model(ro, rx, ry));
            wait_done();
        end
        step();
        check("final_done_low", {63'd0, done}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
